line_fill_memory: RTL and testbench

- Memory-side responder for the cache line-fill protocol issued by Icache/Dcache.
- Accepts one request at a time:
  - a line read: an aligned 4-word burst, one word per cycle after a fixed latency;
  - a single-word write: write-through from Dcache.
- Backed by an internal word array. The array is loadable through a side port for bench and program preload.
- Sits between the cpu top and the cache miss path, replacing the bench-side memory model.

---
 rtl/line_fill_memory_if.sv | 42 ++++
 rtl/line_fill_memory.sv | 164 ++++++++++++++++
 tb/tb_line_fill_memory.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_memory_if.sv
// Request/response bus between the cache miss path and the line-fill memory.
//
// Signals:
//   req_valid   request present (master -> slave)
//   req_ready   responder idle and able to accept (slave -> master)
//   req_write   1 = single-word write, 0 = line read
//   req_addr    word address
//   req_wdata   write data
//   resp_valid  resp_data holds a valid line word this cycle
//   resp_data   line word
//   resp_idx    offset of resp_data within the line
//   resp_last   final word of the burst
//   wr_ack      one-cycle pulse: write committed
interface line_fill_memory_if #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned OffW = $clog2(LINE_WORDS);

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_data;
    logic [OffW-1:0]      resp_idx;
    logic                 resp_last;
    logic                 wr_ack;

    // Cache side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, resp_idx, resp_last, wr_ack
    );

    // Memory side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, resp_idx, resp_last, wr_ack
    );
endinterface

// File: rtl/line_fill_memory.sv
// Memory-side responder for the cache line-fill protocol. Accepts one request at a time:
// a line read returns an aligned LINE_WORDS burst (one word per cycle after LATENCY cycles
// of wait), a single-word write commits and then pulses wr_ack. A side preload port writes
// the array while the responder is idle.
//
// Ports:
//   clk        clock, all state changes on posedge
//   reset_n    synchronous reset, active-high despite the name; does not clear the array
//   bus        request/response bus (slave modport)
//   init_we    preload write enable, honoured only when idle and no request is accepted
//   init_addr  preload word address
//   init_data  preload data
module line_fill_memory #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    line_fill_memory_if.slave    bus,
    input  logic                 init_we,
    input  logic [WORD_SIZE-1:0] init_addr,
    input  logic [WORD_SIZE-1:0] init_data
);
    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned OffW = $clog2(LINE_WORDS);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [OffW-1:0] LastIdx = OffW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StBurst, StWack} state_e;

    // Active-high reset; the port name is historical.
    logic rst;
    assign rst = reset_n;

    logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [IdxW-1:0]      addr_q;
    logic [IdxW-1:0]      base_q;
    logic                 write_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [OffW-1:0]      idx_q;
    logic                 resp_valid_q;
    logic [WORD_SIZE-1:0] resp_data_q;
    logic                 resp_last_q;
    logic                 wr_ack_q;

    logic                 accept;
    logic [OffW-1:0]      rd_off;
    logic [IdxW-1:0]      rd_addr;
    logic                 mem_we;
    logic [IdxW-1:0]      mem_waddr;
    logic [WORD_SIZE-1:0] mem_wdata;

    // Address bits above the array index are aliased away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[WORD_SIZE-1:IdxW], init_addr[WORD_SIZE-1:IdxW]};

    assign accept = bus.req_valid && (state_q == StIdle);

    // Offset of the word registered on the coming edge: 0 when entering the burst,
    // otherwise the one after the word currently presented.
    assign rd_off  = (state_q == StBurst) ? idx_q + OffW'(1) : '0;
    // Base is line-aligned, so OR-ing in the offset never crosses the array end.
    assign rd_addr = base_q | IdxW'(rd_off);

    // Single write port: committed write has priority; preload only when idle and no
    // request is taken on this edge. Nothing is written on a reset edge, so a write still
    // in WAIT is discarded.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == StWait && write_q && cnt_q == '0) begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = wdata_q;
            end else if (init_we && state_q == StIdle && !bus.req_valid) begin
                mem_we    = 1'b1;
                mem_waddr = init_addr[IdxW-1:0];
                mem_wdata = init_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            wr_ack_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StWait;
                        cnt_q   <= CntW'(LATENCY - 1);
                        addr_q  <= bus.req_addr[IdxW-1:0];
                        base_q  <= bus.req_addr[IdxW-1:0] & ~IdxW'(LINE_WORDS - 1);
                        write_q <= bus.req_write;
                        wdata_q <= bus.req_wdata;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        if (write_q) begin
                            state_q  <= StWack;
                            wr_ack_q <= 1'b1;
                        end else begin
                            state_q      <= StBurst;
                            idx_q        <= '0;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= mem_q[rd_addr];
                            resp_last_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StBurst: begin
                    if (idx_q == LastIdx) begin
                        state_q      <= StIdle;
                        idx_q        <= '0;
                        resp_valid_q <= 1'b0;
                        resp_data_q  <= '0;
                        resp_last_q  <= 1'b0;
                    end else begin
                        idx_q       <= idx_q + OffW'(1);
                        resp_data_q <= mem_q[rd_addr];
                        resp_last_q <= (idx_q + OffW'(1)) == LastIdx;
                    end
                end
                StWack: begin
                    state_q  <= StIdle;
                    wr_ack_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    // idx_q is held at 0 outside the burst.
    assign bus.resp_idx   = idx_q;
    assign bus.resp_last  = resp_last_q;
    assign bus.wr_ack     = wr_ack_q;
endmodule

// File: tb/tb_line_fill_memory.sv
// Self-checking bench for line_fill_memory: a reference array plus a queue of expected
// burst beats, popped by a monitor whenever resp_valid is seen.
module tb_line_fill_memory;
    localparam int unsigned WS  = 16;
    localparam int unsigned MD  = 256;
    localparam int unsigned LW  = 4;
    localparam int unsigned LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          init_we = 1'b0;
    logic [WS-1:0] init_addr = '0;
    logic [WS-1:0] init_data = '0;

    line_fill_memory_if #(.WORD_SIZE(WS), .LINE_WORDS(LW)) bus ();

    line_fill_memory #(
        .WORD_SIZE (WS),
        .MEM_DEPTH (MD),
        .LINE_WORDS(LW),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_data(init_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t       expq[$];
    beat_t       mon_exp;
    beat_t       mon_got;
    bit          mon_en = 1'b0;
    int          last_cyc = -1;
    logic [15:0] model [MD];

    // Beat monitor: every valid cycle must match the head of the queue; idle cycles
    // must show zeroed outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.resp_valid === 1'b1) begin
                mon_got = {bus.resp_data, bus.resp_idx, bus.resp_last};
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL resp_beat: got data=%h idx=%0d last=%b, required no beat",
                             bus.resp_data, bus.resp_idx, bus.resp_last);
                end else begin
                    mon_exp = expq.pop_front();
                    if (mon_got !== mon_exp) begin
                        failures++;
                        $display("FAIL resp_beat: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                                 mon_got.data, mon_got.idx, mon_got.last,
                                 mon_exp.data, mon_exp.idx, mon_exp.last);
                    end
                end
                if (bus.resp_last === 1'b1) last_cyc = cyc;
            end else if (bus.resp_data !== 16'h0 || bus.resp_last !== 1'b0 ||
                         bus.resp_idx !== 2'd0 || bus.resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_outputs: got valid=%b data=%h idx=%0d last=%b, required 0",
                         bus.resp_valid, bus.resp_data, bus.resp_idx, bus.resp_last);
            end
        end
    end

    task automatic push_line(input logic [15:0] a);
        logic [7:0] b;
        beat_t      e;
        b = a[7:0] & 8'hFC;
        for (int i = 0; i < LW; i++) begin
            e.data = model[b | 8'(i)];
            e.idx  = 2'(i);
            e.last = (i == LW - 1);
            expq.push_back(e);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        model[a[7:0]] = d;
        @(posedge clk);
        #1;
        init_we = 1'b0;
    endtask

    // Presents a request, waits (bounded) for it to be taken, records expectations and
    // returns the acceptance edge number.
    task automatic start_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                             output int acc);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", bus.req_ready);
        end
        if (wr) model[a[7:0]] = d;
        else push_line(a);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    task automatic wait_quiet();
        int n = 0;
        @(negedge clk);
        while ((expq.size() != 0 || bus.req_ready !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() != 0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL quiet_timeout: pending=%0d req_ready=%b, required 0 and 1",
                     expq.size(), bus.req_ready);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_last, bus.wr_ack} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl: ready/valid/last/ack=%b, required 1000",
                     {bus.req_ready, bus.resp_valid, bus.resp_last, bus.wr_ack});
        end
        checks++;
        if (bus.resp_data !== 16'h0 || bus.resp_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_data: data=%h idx=%0d, required 0 0", bus.resp_data, bus.resp_idx);
        end
        reset_n = 1'b0;
        mon_en  = 1'b1;
    endtask

    task automatic test_read_basic();
        int acc;
        preload(16'h0008, 16'h1111);
        preload(16'h0009, 16'h2222);
        preload(16'h000A, 16'h3333);
        preload(16'h000B, 16'h4444);
        start_req(1'b0, 16'h000A, 16'h0, acc);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_wait: ready=%b valid=%b, required 0 0", bus.req_ready, bus.resp_valid);
        end
        for (int i = 0; i < LW; i++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || cyc != acc + 1 + i) begin
                failures++;
                $display("FAIL read_burst: beat %0d valid=%b ready=%b cyc=%0d, required 1 0 %0d",
                         i, bus.resp_valid, bus.req_ready, cyc, acc + 1 + i);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_done: ready=%b valid=%b, required 1 0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_write();
        int acc;
        int acc2;
        logic [2:0] ack_seq;
        start_req(1'b1, 16'h0009, 16'hBEEF, acc);
        @(negedge clk);
        ack_seq[2] = bus.wr_ack;
        @(negedge clk);
        ack_seq[1] = bus.wr_ack;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_ready: ready=%b during ack, required 0", bus.req_ready);
        end
        @(negedge clk);
        ack_seq[0] = bus.wr_ack;
        checks++;
        if (ack_seq !== 3'b010) begin
            failures++;
            $display("FAIL write_ack: wr_ack sequence=%b, required 010", ack_seq);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_done: ready=%b, required 1", bus.req_ready);
        end
        start_req(1'b0, 16'h0008, 16'h0, acc2);
        wait_quiet();
    endtask

    task automatic test_back_to_back();
        int acc0;
        int n = 0;
        for (int i = 0; i < 8; i++) preload(16'(i), 16'hC000 | 16'(i * 16'h0111));
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        push_line(16'h0000);
        @(posedge clk);
        #1;
        acc0 = cyc;
        bus.req_addr = 16'h0004;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1 || cyc != last_cyc + 1) begin
            failures++;
            $display("FAIL b2b_ready: ready=%b cyc=%0d, required 1 at %0d", bus.req_ready, cyc,
                     last_cyc + 1);
        end
        checks++;
        if (cyc - acc0 != 1 + LAT + LW - 1) begin
            failures++;
            $display("FAIL b2b_occupancy: got %0d cycles, required %0d", cyc - acc0, LAT + LW);
        end
        push_line(16'h0004);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_quiet();
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        int n = 0;
        start_req(1'b0, 16'h0008, 16'h0, acc);
        @(negedge clk);
        while (!(bus.resp_valid === 1'b1 && bus.resp_idx === 2'd1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.resp_idx !== 2'd1) begin
            failures++;
            $display("FAIL rst_find_beat: idx=%0d, required 1", bus.resp_idx);
        end
        #1;
        expq.delete();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_burst: valid=%b ready=%b, required 0 1", bus.resp_valid,
                     bus.req_ready);
        end
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        start_req(1'b0, 16'h0008, 16'h0, acc);
        wait_quiet();
    endtask

    task automatic test_wrap();
        int acc;
        preload(16'h00FC, 16'h5A01);
        preload(16'h03FD, 16'h5A02);
        preload(16'h00FE, 16'h5A03);
        preload(16'h00FF, 16'h5A04);
        start_req(1'b0, 16'h01FE, 16'h0, acc);
        wait_quiet();
    endtask

    task automatic test_init_during_burst();
        int acc;
        int n = 0;
        for (int i = 0; i < 4; i++) preload(16'h0020 + 16'(i), 16'h7700 + 16'(i));
        start_req(1'b0, 16'h0020, 16'h0, acc);
        @(negedge clk);
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        init_we   = 1'b1;
        init_addr = 16'h0022;
        init_data = 16'hDEAD;
        @(negedge clk);
        init_we = 1'b0;
        wait_quiet();
        start_req(1'b0, 16'h0020, 16'h0, acc);
        wait_quiet();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write();
        test_back_to_back();
        test_reset_mid_burst();
        test_wrap();
        test_init_during_burst();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
